// File: rtl/ifu_fetch_if.sv
// Fetch-unit boundary: instruction bus request/response, decode handshake and redirect.
// The fetch unit takes the master view; bus, decoder and execute together form the slave view.
interface ifu_fetch_if;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ready;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;
    logic        ibus_rerror;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic        if_fault;
    logic        id_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output ibus_req, ibus_addr, if_valid, if_instruction, if_pc, if_fault,
        input  ibus_ready, ibus_rvalid, ibus_rdata, ibus_rerror, id_ready, redirect, redirect_pc
    );

    modport slave (
        input  ibus_req, ibus_addr, if_valid, if_instruction, if_pc, if_fault,
        output ibus_ready, ibus_rvalid, ibus_rdata, ibus_rerror, id_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/ifu_fetch.sv
// Sequential instruction fetch with bounded outstanding requests, PC-tagged response FIFO and
// redirect flush. Define IFU_FETCH_FAULT_EN to carry bus errors to decode and stall on them.
module ifu_fetch #(
    parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_b,
    ifu_fetch_if.master bus
);
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          PTR_W = $clog2(FIFO_DEPTH);
    localparam int          CNT_W = PTR_W + 1;
    localparam int          TAG_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [31:0]      pc_reg;
    logic [1:0]       out_cnt_reg;
    logic [1:0]       drop_reg;
    logic             active_reg;
    logic [CNT_W-1:0] fifo_cnt_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [TAG_W-1:0] tag_rd_reg;
    logic [TAG_W-1:0] tag_wr_reg;
    logic [31:0]      tag_pc_reg    [MAX_OUTSTANDING];
    logic [31:0]      fifo_pc_reg   [FIFO_DEPTH];
    logic [31:0]      fifo_data_reg [FIFO_DEPTH];

    logic        fire;
    logic        push;
    logic        pop;
    logic        fifo_empty;
    logic        stop_issue;
    logic        head_fault;
    logic [31:0] live_cnt;

    function automatic logic [TAG_W-1:0] tag_inc(input logic [TAG_W-1:0] p);
        return (p == TAG_W'(MAX_OUTSTANDING - 1)) ? '0 : p + TAG_W'(1);
    endfunction

    // Responses still owed to the live stream plus buffered words bound the next request,
    // so every accepted response always has a FIFO slot.
    assign live_cnt   = 32'(out_cnt_reg) - 32'(drop_reg) + 32'(fifo_cnt_reg);
    assign fifo_empty = (fifo_cnt_reg == '0);
    assign fire       = bus.ibus_req & bus.ibus_ready;
    assign push       = bus.ibus_rvalid && (drop_reg == 2'd0) && !bus.redirect;
    assign pop        = !fifo_empty && bus.id_ready;

`ifdef IFU_FETCH_FAULT_EN
    logic fifo_fault_reg [FIFO_DEPTH];
    logic fault_stop_reg;

    assign stop_issue = fault_stop_reg;
    assign head_fault = fifo_fault_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (!rst_b || bus.redirect) begin
            fault_stop_reg <= 1'b0;
        end else if (push && bus.ibus_rerror) begin
            fault_stop_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_fault_reg[wr_ptr_reg] <= bus.ibus_rerror;
        end
    end
`else
    assign stop_issue = 1'b0;
    assign head_fault = 1'b0;
`endif

    // active_reg holds the request low for the first cycle out of reset.
    assign bus.ibus_req       = active_reg && !stop_issue && !bus.redirect
                                && (live_cnt < 32'(FIFO_DEPTH))
                                && (out_cnt_reg < 2'(MAX_OUTSTANDING));
    assign bus.ibus_addr      = pc_reg;
    assign bus.if_valid       = !fifo_empty;
    assign bus.if_pc          = fifo_empty ? RESET_VECTOR : fifo_pc_reg[rd_ptr_reg];
    assign bus.if_instruction = (fifo_empty || head_fault) ? NOP : fifo_data_reg[rd_ptr_reg];
    assign bus.if_fault       = !fifo_empty && head_fault;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            pc_reg       <= RESET_VECTOR;
            out_cnt_reg  <= 2'd0;
            drop_reg     <= 2'd0;
            active_reg   <= 1'b0;
            fifo_cnt_reg <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            tag_rd_reg   <= '0;
            tag_wr_reg   <= '0;
        end else begin
            active_reg  <= 1'b1;
            out_cnt_reg <= out_cnt_reg + 2'(fire) - 2'(bus.ibus_rvalid);
            if (fire) begin
                tag_wr_reg <= tag_inc(tag_wr_reg);
            end
            if (bus.ibus_rvalid) begin
                tag_rd_reg <= tag_inc(tag_rd_reg);
            end
            // Tags stay aligned across a redirect; drop_reg marks how many are stale.
            if (bus.redirect) begin
                pc_reg       <= {bus.redirect_pc[31:2], 2'b00};
                drop_reg     <= out_cnt_reg - 2'(bus.ibus_rvalid);
                fifo_cnt_reg <= '0;
                rd_ptr_reg   <= '0;
                wr_ptr_reg   <= '0;
            end else begin
                if (fire) begin
                    pc_reg <= pc_reg + 32'd4;
                end
                if (bus.ibus_rvalid && (drop_reg != 2'd0)) begin
                    drop_reg <= drop_reg - 2'd1;
                end
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                end
                fifo_cnt_reg <= fifo_cnt_reg + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fire) begin
            tag_pc_reg[tag_wr_reg] <= pc_reg;
        end
        if (push) begin
            fifo_pc_reg[wr_ptr_reg]   <= tag_pc_reg[tag_rd_reg];
            fifo_data_reg[wr_ptr_reg] <= bus.ibus_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            assert (!(bus.ibus_rvalid && (out_cnt_reg == 2'd0)));
            assert (!(push && !pop && (fifo_cnt_reg == CNT_W'(FIFO_DEPTH))));
        end
    end
endmodule
